// File: rtl/jt51_acc_pkg.sv
// Shared constants and helpers for the time-multiplexed FM output accumulator.
// Operator order within a frame is M1, M2, C1, C2.
package jt51_acc_pkg;

  localparam logic [1:0] OP_M1 = 2'd0;
  localparam logic [1:0] OP_M2 = 2'd1;
  localparam logic [1:0] OP_C1 = 2'd2;
  localparam logic [1:0] OP_C2 = 2'd3;

  // Indexed [algorithm][operator]; bit set means that operator is a carrier.
  localparam logic [7:0][3:0] CARRIER_MASK = {
    4'hf, 4'he, 4'he, 4'hc, 4'h8, 4'h8, 4'h8, 4'h8
  };

  // The noise generator output is aligned to a 14-bit operator sample.
  localparam int unsigned NOISE_ALIGN = 14;

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                             input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/jt51_sh.sv
// Fixed-length delay line: drop returns the value written stages cen-cycles earlier.
// The bram variant keeps data in an unreset memory addressed by a rotating pointer.
module jt51_sh #(
  parameter int unsigned width  = 5,
  parameter int unsigned stages = 32,
  parameter int unsigned bram   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [width-1:0] din,
  output logic [width-1:0] drop
);

  if (bram != 0) begin : g_ram
    localparam int unsigned PW = $clog2(stages);
    localparam logic [PW-1:0] PLAST = PW'(stages - 1);

    logic [width-1:0] mem [stages];
    logic [PW-1:0]    ptr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr <= '0;
      else if (cen) ptr <= (ptr == PLAST) ? '0 : ptr + PW'(1);
    end

    always_ff @(posedge clk) begin
      if (cen) mem[ptr] <= din;
    end

    assign drop = mem[ptr];
  end else begin : g_reg
    logic [width-1:0] sr [stages];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(stages); i++) sr[i] <= '0;
      end else if (cen) begin
        sr[0] <= din;
        for (int i = 1; i < int'(stages); i++) sr[i] <= sr[i-1];
      end
    end

    assign drop = sr[stages-1];
  end

endmodule

// File: rtl/jt51_acc_mix.sv
// FM output accumulator: sums carrier operators per channel, applies attenuation and pan,
// and emits one saturated stereo sample per frame with a valid strobe and sticky clip flags.
module jt51_acc_mix
  import jt51_acc_pkg::*;
#(
  parameter int unsigned CH  = 8,
  parameter int unsigned OPS = 4,
  parameter int unsigned IW  = 14,
  parameter int unsigned OW  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cen,
  input  logic                         sync,
  input  logic [IW-1:0]                op_out,
  input  logic [2:0]                   con_I,
  input  logic [1:0]                   rl_I,
  input  logic [2:0]                   att_I,
  input  logic                         ne,
  input  logic [11:0]                  noise_mix,
  input  logic                         clip_clr,
  output logic signed [OW-1:0]         left,
  output logic signed [OW-1:0]         right,
  output logic                         sample_valid,
  output logic                         clip_l,
  output logic                         clip_r,
  output logic [$clog2(CH*OPS)-1:0]    slot
);

  localparam int unsigned SW = $clog2(CH * OPS);
  localparam int unsigned BW = IW + 2;
  localparam int unsigned AW = IW + 2 + $clog2(CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(CH * OPS - 1);

  logic [SW-1:0]        slot_q;
  logic [SW-1:0]        cur;
  logic                 resync;
  logic                 last;
  logic [1:0]           op;
  logic                 carrier;
  logic signed [IW-1:0] noise_s;
  logic signed [IW-1:0] sample;
  logic signed [IW-1:0] term;
  logic signed [BW-1:0] buf_drop;
  logic signed [BW-1:0] buf_din;
  logic signed [BW-1:0] scaled;
  logic signed [AW-1:0] acc_l_q, acc_r_q;
  logic signed [AW-1:0] add_l, add_r;
  logic signed [AW-1:0] sum_l, sum_r;
  logic signed [63:0]   wide_l, wide_r;
  logic signed [63:0]   sat_l, sat_r;
  logic                 clip_set_l, clip_set_r;

  // A sync away from slot 0 restarts the frame: this input becomes slot 0.
  assign resync  = sync && (slot_q != '0);
  assign cur     = sync ? '0 : slot_q;
  assign last    = (cur == LAST_SLOT);
  assign op      = cur[SW-1 -: 2];
  assign carrier = CARRIER_MASK[con_I][op];
  assign slot    = slot_q;

  always_comb begin
    noise_s = {{(IW - 12){noise_mix[11]}}, noise_mix};
    noise_s = noise_s <<< (IW - NOISE_ALIGN);
    sample  = (ne && last) ? noise_s : $signed(op_out);
    term    = carrier ? sample : '0;
    // On C2 this is the channel total; on M1 it reloads the channel's buffer entry.
    buf_din = (op == OP_M1) ? BW'(term) : buf_drop + BW'(term);
    scaled  = buf_din >>> att_I;
    add_l   = (op == OP_C2 && rl_I[0]) ? AW'(scaled) : '0;
    add_r   = (op == OP_C2 && rl_I[1]) ? AW'(scaled) : '0;
    sum_l   = (resync ? '0 : acc_l_q) + add_l;
    sum_r   = (resync ? '0 : acc_r_q) + add_r;
    wide_l  = 64'(sum_l);
    wide_r  = 64'(sum_r);
    sat_l   = sat(wide_l, OW);
    sat_r   = sat(wide_r, OW);
    clip_set_l = (sat_l != wide_l);
    clip_set_r = (sat_r != wide_r);
  end

  jt51_sh #(
    .width  (BW),
    .stages (CH),
    .bram   (1)
  ) u_sum_buf (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .din  (buf_din),
    .drop (buf_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      clip_l       <= 1'b0;
      clip_r       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (clip_clr) begin
        clip_l <= 1'b0;
        clip_r <= 1'b0;
      end
      if (cen) begin
        slot_q <= last ? '0 : cur + SW'(1);
        if (last) begin
          acc_l_q      <= '0;
          acc_r_q      <= '0;
          left         <= sat_l[OW-1:0];
          right        <= sat_r[OW-1:0];
          sample_valid <= 1'b1;
          // Placed after the clear so a simultaneous saturation keeps the flag set.
          if (clip_set_l) clip_l <= 1'b1;
          if (clip_set_r) clip_r <= 1'b1;
        end else begin
          acc_l_q <= sum_l;
          acc_r_q <= sum_r;
        end
      end
    end
  end

endmodule
